fc_layer_ctrl: RTL and testbench
================================

Name: fc_layer_ctrl

Overview:
- Sequencer for the fully connected (FC) layer of the digit-recognition datapath.
- Walks the dual-lane FC weight memory and the FC input-activation buffer, one output neuron at a time.
- Drives MAC enable/clear strobes aligned to memory read latency; presents each finished neuron on a valid/ready handshake to the classifier/argmax stage.
- Replaces the free-running weight-read counter with a start/busy/done controlled block.

Parameters:
- N_IN, 384, inputs per neuron; even; lane 0 covers 0..N_IN/2-1, lane 1 covers N_IN/2..N_IN-1.
- N_OUT, 10, output neurons (digit classes).
- RD_LAT, 1, weight/input memory read latency in cycles; legal range 1..4.
- AW, 12, weight address width; must satisfy N_OUT*N_IN <= 2^AW.
- XW, 9, input-buffer address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin layer; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final neuron handshake.
- w_rd_en  out  1  weight-memory and input-buffer read enable.
- w_addr0  out  AW  lane-0 weight address.
- w_addr1  out  AW  lane-1 weight address.
- x_addr0  out  XW  lane-0 input-buffer address.
- x_addr1  out  XW  lane-1 input-buffer address.
- mac_en  out  1  read data valid this cycle; accumulate both lanes.
- acc_first  out  1  with mac_en: load products instead of adding.
- out_valid  out  1  accumulator holds a finished neuron.
- out_ready  in  1  downstream accepts the neuron.
- out_idx  out  4  neuron index 0..N_OUT-1 accompanying out_valid.

Behaviour:
- Reset: all outputs and addresses 0, busy=0, done=0, FSM=IDLE, neuron counter o=0, cycle counter k=0, mac pipeline cleared. Reset mid-operation aborts immediately; no done pulse.
- Definitions: H=N_IN/2.
- FSM states:
  - IDLE: start=1 moves to RUN next cycle with o=0, k=0, busy=1. start=0 holds IDLE.
  - RUN: w_rd_en=1 for k=0..H-1.
    - w_addr0 = o*N_IN+k, w_addr1 = o*N_IN+H+k.
    - x_addr0 = k, x_addr1 = H+k.
    - After k=H-1, go to DRAIN.
  - DRAIN: w_rd_en=0 for exactly RD_LAT cycles, then EMIT.
  - EMIT: out_valid=1, out_idx=o, held stable until out_valid&&out_ready.
    - On handshake with o<N_OUT-1: o++, k=0, go to RUN.
    - On handshake with o=N_OUT-1: go to IDLE, busy=0, done=1 for the following cycle.
- MAC timing:
  - mac_en is w_rd_en delayed by RD_LAT cycles through a shift register.
  - acc_first is (RUN && k==0) delayed identically.
  - Exactly H mac_en pulses per neuron; the last lands in the final DRAIN cycle.
- Addresses: hold their last values while not in RUN. Computed with an incrementing base (base += N_IN per neuron); no multiplier. Width is AW; no wrap occurs for legal parameters.
- start while busy is ignored. start on the same cycle as done is ignored; IDLE samples start from the next cycle.
- Cycle count: with out_ready held high, each neuron takes H+RD_LAT+1 cycles. Defaults give 194 per neuron; done is high 1941 cycles after the start-accept edge.

Optional Feature:
- Macro: FC_BIAS_EN.
- Defined:
  - Adds ports b_rd_en (out, 1), b_addr (out, 4) and bias_add (out, 1).
  - b_rd_en=1 with b_addr=o in the first RUN cycle of each neuron.
  - bias_add asserts coincident with that neuron's acc_first, so the accumulator loads bias+products.
  - Cycle count is unchanged.
- Undefined: ports are absent; accumulator starts from the first products only.

Test Plan:
- Defaults, start pulse, out_ready=1 -> 10 EMIT handshakes with out_idx 0..9; done high exactly 1941 cycles after the start edge; 1920 total mac_en pulses.
- Neuron 3, k=5 -> w_addr0=1157, w_addr1=1349, x_addr0=5, x_addr1=197; acc_first only on the first mac_en of each neuron.
- out_ready low 7 cycles during EMIT of neuron 2 -> out_valid and out_idx=2 held stable; next RUN starts the cycle after the handshake; total delay +7.
- start pulsed during RUN and on the done cycle -> no effect; a new start the cycle after done begins a fresh layer at o=0.
- reset asserted mid-RUN of neuron 4 -> all outputs 0 asynchronously, no done pulse; a subsequent start runs the full layer correctly.
- RD_LAT=2 with FC_BIAS_EN defined -> mac_en lags w_rd_en by 2 cycles; 195-cycle neurons; bias_add coincides with acc_first; b_addr equals out_idx.

Source files
------------

// File: rtl/fc_layer_ctrl.sv
// FC-layer sequencer: walks dual-lane weights and input activations one neuron at a time,
// strobes the MAC in step with memory read latency, and hands each neuron to argmax.
// Optional bias fetch is enabled by defining FC_BIAS_EN.
module fc_layer_ctrl #(
  parameter int N_IN   = 384,
  parameter int N_OUT  = 10,
  parameter int RD_LAT = 1,
  parameter int AW     = 12,
  parameter int XW     = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          w_rd_en,
  output logic [AW-1:0] w_addr0,
  output logic [AW-1:0] w_addr1,
  output logic [XW-1:0] x_addr0,
  output logic [XW-1:0] x_addr1,
  output logic          mac_en,
  output logic          acc_first,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_idx
`ifdef FC_BIAS_EN
  ,
  output logic          b_rd_en,
  output logic [3:0]    b_addr,
  output logic          bias_add
`endif
);

  localparam int H  = N_IN / 2;
  localparam int KW = (H > 1) ? $clog2(H) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(H - 1);
  localparam logic [3:0]    O_LAST = 4'(N_OUT - 1);
  localparam logic [2:0]    D_LAST = 3'(RD_LAT - 1);
  localparam logic [AW-1:0] NIN_A  = AW'(N_IN);
  localparam logic [AW-1:0] H_A    = AW'(H);
  localparam logic [XW-1:0] H_X    = XW'(H);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, EMIT} state_t;

  state_t          state, state_n;
  logic [3:0]      o;
  logic [KW-1:0]   k;
  logic [2:0]      dcnt;
  logic [AW-1:0]   base;
  logic            first_rd;
  logic [RD_LAT-1:0] en_sr;
  logic [RD_LAT-1:0] first_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // done is still high in the first IDLE cycle, which blocks a start landing on it
  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    w_rd_en   = 1'b0;
    out_valid = 1'b0;
    first_rd  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !done) state_n = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        w_rd_en  = 1'b1;
        first_rd = (k == '0);
        if (k == K_LAST) state_n = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (dcnt == D_LAST) state_n = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = (o == O_LAST) ? IDLE : RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_idx = o;

  // Addresses are registered and advanced incrementally; base steps by N_IN per neuron
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o       <= '0;
      k       <= '0;
      dcnt    <= '0;
      base    <= '0;
      done    <= 1'b0;
      w_addr0 <= '0;
      w_addr1 <= '0;
      x_addr0 <= '0;
      x_addr1 <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (state_n == RUN) begin
            o       <= '0;
            k       <= '0;
            base    <= '0;
            w_addr0 <= '0;
            w_addr1 <= H_A;
            x_addr0 <= '0;
            x_addr1 <= H_X;
          end
        end
        RUN: begin
          dcnt <= '0;
          if (k != K_LAST) begin
            k       <= k + 1'b1;
            w_addr0 <= w_addr0 + 1'b1;
            w_addr1 <= w_addr1 + 1'b1;
            x_addr0 <= x_addr0 + 1'b1;
            x_addr1 <= x_addr1 + 1'b1;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
        end
        EMIT: begin
          if (out_ready) begin
            if (o == O_LAST) begin
              done <= 1'b1;
            end else begin
              o       <= o + 1'b1;
              k       <= '0;
              base    <= base + NIN_A;
              w_addr0 <= base + NIN_A;
              w_addr1 <= base + NIN_A + H_A;
              x_addr0 <= '0;
              x_addr1 <= H_X;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_sr    <= '0;
      first_sr <= '0;
    end else begin
      en_sr[0]    <= w_rd_en;
      first_sr[0] <= first_rd;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        en_sr[i]    <= en_sr[i-1];
        first_sr[i] <= first_sr[i-1];
      end
    end
  end

  assign mac_en    = en_sr[RD_LAT-1];
  assign acc_first = first_sr[RD_LAT-1];

`ifdef FC_BIAS_EN
  // Bias memory shares the weight read latency, so it lines up with acc_first
  assign b_rd_en  = first_rd;
  assign b_addr   = o;
  assign bias_add = acc_first;
`endif

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Scoreboard bench for fc_layer_ctrl: stimulus queues expected handshakes, done pulses and
// address probes; a negedge monitor pops and compares them against the DUT.
module tb_fc_layer_ctrl;

  localparam int N_IN   = 384;
  localparam int N_OUT  = 10;
  localparam int RD_LAT = 1;
  localparam int AW     = 12;
  localparam int XW     = 9;
  localparam int H      = N_IN / 2;
  localparam int PER    = H + RD_LAT + 1;
  localparam int STALL  = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done, w_rd_en, mac_en, acc_first, out_valid;
  logic          out_ready;
  logic [AW-1:0] w_addr0, w_addr1;
  logic [XW-1:0] x_addr0, x_addr1;
  logic [3:0]    out_idx;
`ifdef FC_BIAS_EN
  logic          b_rd_en, bias_add;
  logic [3:0]    b_addr;
`endif

  fc_layer_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .RD_LAT(RD_LAT), .AW(AW), .XW(XW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_addr0(w_addr0), .w_addr1(w_addr1),
    .x_addr0(x_addr0), .x_addr1(x_addr1), .mac_en(mac_en), .acc_first(acc_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx)
`ifdef FC_BIAS_EN
    , .b_rd_en(b_rd_en), .b_addr(b_addr), .bias_add(bias_add)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; int cyc; } exp_t;
  typedef struct { int cyc; int rd; int bsy; int w0; int w1; int x0; int x1; } probe_t;

  exp_t   oq[$];
  int     dq[$];
  probe_t pq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, inputs change 1 time unit after the rising edge
  int mac_n = 0, first_n = 0, layer_mac = 0;
  always @(negedge clk) begin
    exp_t   e;
    probe_t p;
    if (reset) begin
      mac_n = 0; first_n = 0; layer_mac = 0;
    end else begin
      if (acc_first) begin
        chk("acc_first_with_mac_en", int'(mac_en), 1);
        chk("acc_first_on_first_mac", mac_n, 0);
        first_n++;
      end
`ifdef FC_BIAS_EN
      if (acc_first || bias_add) chk("bias_add_vs_acc_first", int'(bias_add), int'(acc_first));
      if (b_rd_en) chk("b_addr_vs_out_idx", int'(b_addr), int'(out_idx));
`endif
      if (mac_en) begin mac_n++; layer_mac++; end
      if (out_valid) begin
        if (oq.size() == 0) chk("out_valid_unexpected", int'(out_valid), 0);
        else begin
          chk("out_idx", int'(out_idx), oq[0].idx);
          if (out_ready) begin
            e = oq.pop_front();
            chk("handshake_cycle", cyc, e.cyc);
            chk("mac_en_per_neuron", mac_n, H);
            chk("acc_first_per_neuron", first_n, 1);
            mac_n = 0; first_n = 0;
          end
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("done_unexpected", int'(done), 0);
        else begin
          chk("done_cycle", cyc, dq.pop_front());
          chk("mac_en_per_layer", layer_mac, N_OUT * H);
          layer_mac = 0;
        end
      end
      if (pq.size() > 0 && cyc >= pq[0].cyc) begin
        p = pq.pop_front();
        chk("probe_cycle", cyc, p.cyc);
        chk("probe_w_rd_en", int'(w_rd_en), p.rd);
        chk("probe_busy", int'(busy), p.bsy);
        chk("probe_w_addr0", int'(w_addr0), p.w0);
        chk("probe_w_addr1", int'(w_addr1), p.w1);
        chk("probe_x_addr0", int'(x_addr0), p.x0);
        chk("probe_x_addr1", int'(x_addr1), p.x1);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start(output int t0);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; t0 = cyc;
  endtask

  // t0 is the cycle-counter value during the first RUN cycle of the layer
  task automatic push_layer(input int t0, input int n_neur, input int stall_idx, input bit exp_done);
    exp_t e;
    for (int n = 0; n < n_neur; n++) begin
      e.idx = n;
      e.cyc = t0 + (n + 1) * PER - 1 + ((stall_idx >= 0 && n >= stall_idx) ? STALL : 0);
      oq.push_back(e);
    end
    if (exp_done) dq.push_back(t0 + N_OUT * PER + ((stall_idx >= 0) ? STALL : 0));
  endtask

  task automatic push_probe(input int c, input int rd, input int bsy,
                            input int w0, input int w1, input int x0, input int x1);
    probe_t p;
    p.cyc = c; p.rd = rd; p.bsy = bsy; p.w0 = w0; p.w1 = w1; p.x0 = x0; p.x1 = x1;
    pq.push_back(p);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_w_rd_en"}, int'(w_rd_en), 0);
    chk({tag, "_w_addr0"}, int'(w_addr0), 0);
    chk({tag, "_w_addr1"}, int'(w_addr1), 0);
    chk({tag, "_x_addr0"}, int'(x_addr0), 0);
    chk({tag, "_x_addr1"}, int'(x_addr1), 0);
    chk({tag, "_mac_en"}, int'(mac_en), 0);
    chk({tag, "_acc_first"}, int'(acc_first), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_idx"}, int'(out_idx), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0a, t0b, t0c, t0d;
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Layer A: free-flowing, address probes, a start pulse mid-RUN that must be ignored
    do_start(t0a);
    push_layer(t0a, N_OUT, -1, 1'b1);
    push_probe(t0a,        1, 1,    0,  192,   0, 192);
    push_probe(t0a + 192,  0, 1,  191,  383, 191, 383);
    push_probe(t0a + 587,  1, 1, 1157, 1349,   5, 197);
    push_probe(t0a + 1937, 1, 1, 3647, 3839, 191, 383);
    push_probe(t0a + 1940, 0, 0, 3647, 3839, 191, 383);
    wait_cyc(t0a + 100);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;

    // Start raised on the done cycle and held one more cycle: accepted only on the second
    wait_cyc(t0a + 1940);
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; start = 1'b0;
    t0b = t0a + 1942;

    // Layer B: fresh layer from o=0, out_ready stalled for 7 EMIT cycles of neuron 2
    push_layer(t0b, N_OUT, 2, 1'b1);
    push_probe(t0b, 1, 1, 0, 192, 0, 192);
    wait_cyc(t0b + 3 * PER - 1);
    out_ready = 1'b0;
    repeat (STALL) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_cyc(t0b + N_OUT * PER + STALL + 5);

    // Layer C: aborted by reset during RUN of neuron 4
    do_start(t0c);
    push_layer(t0c, 4, -1, 1'b0);
    wait_cyc(t0c + 4 * PER + 50);
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_pending_outputs", oq.size(), 0);

    // Layer D: full layer after the abort
    do_start(t0d);
    push_layer(t0d, N_OUT, -1, 1'b1);
    push_probe(t0d, 1, 1, 0, 192, 0, 192);
    wait_cyc(t0d + N_OUT * PER + 10);

    chk("final_outputs_pending", oq.size(), 0);
    chk("final_done_pending", dq.size(), 0);
    chk("final_probes_pending", pq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
